// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a req/ack memory port and buffers
// {instruction, pc} pairs for decode. Define IFQ_BYPASS_EN to forward an ack straight to an empty head.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic [31:0]              inst_npc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];

  logic            head_valid;
  logic            bypass;
  logic            byp_take;
  logic            push;
  logic            pop;
  logic            flush;
  logic [CW-1:0]   count_after;
  logic [31:0]     target_pc;

  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign head_valid = (count_q != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = (count_q == '0) && (state_q == REQ) && imem_ack && !redirect;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never occupies a FIFO slot.
  assign byp_take    = bypass && inst_ready;
  assign pop         = head_valid && inst_ready && !redirect;
  assign push        = (state_q == REQ) && imem_ack && !redirect && !byp_take;
  assign count_after = count_q + CW'(push) - CW'(pop);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    inst_valid = head_valid || bypass;
    inst       = 32'h0;
    inst_pc    = 32'h0;
    if (head_valid) begin
      inst    = data_q[rd_ptr_q];
      inst_pc = pc_q[rd_ptr_q];
    end else if (bypass) begin
      inst    = imem_rdata;
      inst_pc = addr_q;
    end
  end

  assign inst_npc  = inst_pc + 32'd4;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign count     = count_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target_pc;
        end else if (count_q < CW'(DEPTH)) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target_pc;
          if (imem_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_after < CW'(DEPTH)) begin
            addr_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target_pc;
        end
        if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_after;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which slots hold live entries.
  always_ff @(posedge clock) begin
    if (push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized and directed bench for ifetch_queue against a queue-based behavioural model.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_npc;
  logic        inst_ready;
  logic [2:0]  count;

  always #5 clock = ~clock;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_npc(inst_npc),
    .inst_ready(inst_ready), .count(count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch, m_addr;
  bit          m_req, m_drop, m_known;

  // memory and stimulus knobs
  int          lat = 1;
  int          wcnt = 0;
  bit          rdy = 1'b1;
  int          arm_mode = 0;
  logic [31:0] arm_addr, arm_target;
  bit          arm_fired;
  logic [31:0] acked[$];
  logic [31:0] seen_pc[$];
  logic [31:0] seen_npc[$];

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic model_update(input bit rst_v, input bit red_v, input logic [31:0] rpc_v,
                              input bit ack_v, input logic [31:0] rdata_v, input bit rdy_v);
    int   n;
    bit   do_pop, take;
    ent_t e;
    if (!rst_v) begin
      mq.delete();
      m_fetch = RESET_PC; m_addr = RESET_PC; m_req = 0; m_drop = 0; m_known = 1;
      return;
    end
    n      = mq.size();
    do_pop = (n > 0) && rdy_v && !red_v;
    if (red_v) begin
      mq.delete();
      m_fetch = rpc_v & ~32'h3;
      if (m_req && !ack_v) m_drop = 1;
      else begin m_req = 0; m_drop = 0; end
    end else if (m_req && ack_v) begin
      if (m_drop) begin
        m_drop = 0; m_req = 0;
      end else begin
        take = BYP && (n == 0) && rdy_v;
        if (do_pop) void'(mq.pop_front());
        if (!take) begin e.pc = m_fetch; e.data = rdata_v; mq.push_back(e); end
        m_fetch = m_fetch + 32'd4;
        m_addr  = m_fetch;
        m_req   = (mq.size() < DEPTH);
      end
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (!m_req) begin m_req = (n < DEPTH); m_addr = m_fetch; end
    end
  endtask

  task automatic step(input bit rst_in, input bit red_in, input logic [31:0] rpc_in);
    bit          rst_v, red_v, ack_t, ack_v, exp_valid;
    logic [31:0] rpc_v, exp_inst, exp_pc;
    @(negedge clock);
    rst_v = rst_in; red_v = red_in; rpc_v = rpc_in;
    ack_t = imem_req && (wcnt >= lat);
    if (arm_mode == 3 && imem_req && !ack_t && count == 3'd2) begin
      rst_v = 0; arm_mode = 0; arm_fired = 1;
    end
    ack_v = rst_v && ack_t;
    if (arm_mode == 1 && ack_v && imem_addr == arm_addr) begin
      red_v = 1; rpc_v = arm_target; arm_mode = 0; arm_fired = 1;
    end
    if (arm_mode == 2 && imem_req && !ack_v && imem_addr == arm_addr) begin
      red_v = 1; rpc_v = arm_target; arm_mode = 0; arm_fired = 1;
    end
    reset       = rst_v;
    redirect    = red_v;
    redirect_pc = rpc_v;
    inst_ready  = rdy;
    imem_ack    = ack_v;
    imem_rdata  = ack_v ? mem_word(imem_addr) : $urandom;
    if (ack_v) acked.push_back(imem_addr);
    #1;
    if (m_known) begin
      exp_valid = 0; exp_inst = 32'h0; exp_pc = 32'h0;
      if (mq.size() > 0) begin
        exp_valid = 1; exp_inst = mq[0].data; exp_pc = mq[0].pc;
      end else if (BYP && m_req && !m_drop && ack_v && !red_v) begin
        exp_valid = 1; exp_inst = imem_rdata; exp_pc = m_addr;
      end
      check("count", count, mq.size());
      check("imem_req", imem_req, m_req);
      if (m_req) check("imem_addr", imem_addr, m_addr);
      check("inst_valid", inst_valid, exp_valid);
      check("inst", inst, exp_inst);
      check("inst_pc", inst_pc, exp_pc);
      if (exp_valid) check("inst_npc", inst_npc, exp_pc + 32'd4);
    end
    if (rst_v && inst_valid && rdy && !red_v) begin
      seen_pc.push_back(inst_pc);
      seen_npc.push_back(inst_npc);
    end
    model_update(rst_v, red_v, rpc_v, ack_v, imem_rdata, rdy);
    wcnt = (!rst_v || !imem_req || ack_v) ? 0 : wcnt + 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 32'h0);
  endtask

  task automatic do_reset();
    step(0, 0, 32'h0);
    acked.delete(); seen_pc.delete(); seen_npc.delete();
  endtask

  task automatic run_until_fired(input int budget);
    arm_fired = 0;
    for (int i = 0; i < budget && !arm_fired; i++) step(1, 0, 32'h0);
  endtask

  initial begin
    reset = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0; inst_ready = 0;
    m_known = 0;

    // reset state
    do_reset();
    step(0, 0, 32'h0);
    check("rst_count", count, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);

    // one-cycle memory, decode always ready
    acked.delete(); seen_pc.delete(); seen_npc.delete();
    rdy = 1; lat = 1;
    run(20);
    check("A_addr0", q_at(acked, 0), 32'h3000);
    check("A_addr1", q_at(acked, 1), 32'h3004);
    check("A_addr2", q_at(acked, 2), 32'h3008);
    check("A_pc0", q_at(seen_pc, 0), 32'h3000);
    check("A_pc1", q_at(seen_pc, 1), 32'h3004);
    check("A_pc2", q_at(seen_pc, 2), 32'h3008);
    check("A_npc0", q_at(seen_npc, 0), 32'h3004);

    // zero-wait memory, decode stalled: fill, then free one slot
    do_reset();
    rdy = 0; lat = 0;
    run(12);
    check("B_full", count, 4);
    check("B_req_low", imem_req, 0);
    rdy = 1; step(1, 0, 32'h0); rdy = 0;
    acked.delete();
    run(8);
    check("B_nreq", acked.size(), 1);
    check("B_addr", q_at(acked, 0), 32'h3010);
    check("B_refull", count, 4);

    // redirect while the 3008 request is waiting
    do_reset();
    rdy = 1; lat = 3;
    arm_mode = 2; arm_addr = 32'h3008; arm_target = 32'h0000_4001;
    run_until_fired(80);
    check("C_fired", arm_fired, 1);
    acked.delete(); seen_pc.delete();
    step(1, 0, 32'h0);
    check("C_hold_req", imem_req, 1);
    check("C_hold_addr", imem_addr, 32'h3008);
    run(30);
    check("C_ack_old", q_at(acked, 0), 32'h3008);
    check("C_ack_new", q_at(acked, 1), 32'h4000);
    check("C_first_pc", q_at(seen_pc, 0), 32'h4000);

    // redirect on the same cycle as the 3004 ack
    do_reset();
    rdy = 1; lat = 1;
    arm_mode = 1; arm_addr = 32'h3004; arm_target = 32'h0000_5000;
    run_until_fired(40);
    check("D_fired", arm_fired, 1);
    acked.delete();
    step(1, 0, 32'h0);
    check("D_count", count, 0);
    run(10);
    check("D_next_addr", q_at(acked, 0), 32'h5000);

    // address wrap
    do_reset();
    rdy = 0; lat = 0;
    step(1, 1, 32'hFFFF_FFFC);
    run(8);
    check("E_pc0", inst_pc, 32'hFFFF_FFFC);
    check("E_npc0", inst_npc, 32'h0000_0000);
    check("E_inst0", inst, mem_word(32'hFFFF_FFFC));
    rdy = 1; step(1, 0, 32'h0); rdy = 0;
    step(1, 0, 32'h0);
    check("E_pc1", inst_pc, 32'h0000_0000);

    // reset pulled while a request is outstanding with two entries queued
    do_reset();
    rdy = 0; lat = 2;
    arm_mode = 3;
    run_until_fired(40);
    check("F_fired", arm_fired, 1);
    step(1, 0, 32'h0);
    check("F_count", count, 0);
    check("F_req", imem_req, 0);
    check("F_valid", inst_valid, 0);
    acked.delete();
    run(10);
    check("F_first", q_at(acked, 0), 32'h3000);

    // randomized traffic
    arm_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      bit          r, rd;
      if (i % 50 == 0) lat = $urandom_range(0, 3);
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 199) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      t   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, rd, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch stage between a variable-latency instruction memory and the IF/ID pipeline register.
- Fetches sequential words from the fetch PC using a req/ack handshake, and buffers them with their PCs in a small FIFO.
- Presents the head entry to the decode side with valid/ready flow control.
- Flushes the FIFO and restarts at a new PC on branch/jump redirect.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- redirect  in  1  flush the queue and restart fetching at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  32  word-aligned request address.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  head entry is available.
- inst  out  32  head instruction; 32'h0 when inst_valid=0.
- inst_pc  out  32  PC of the head instruction.
- inst_npc  out  32  inst_pc + 4.
- inst_ready  in  1  consumer accepts the head this cycle (driven from IF_ID_write).
- count  out  $clog2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (reset=0 at an edge):
  - count=0, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, state=IDLE.
  - inst_valid=0, inst=0, inst_pc=0.
  - imem_ack is ignored while reset is low.
  - Reset asserted mid-request abandons that request; the memory shares the same reset.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding, response will be kept.
  - DISCARD: request outstanding, response will be dropped.
- Issue rule: a request is issued when count + outstanding < DEPTH and no redirect is active.
  - imem_req and imem_addr are registered outputs.
  - imem_addr = fetch_pc and is held stable while imem_req=1 until ack.
  - At most one request is outstanding.
- IDLE -> REQ when the issue rule holds; imem_req rises on the next edge.
- REQ, imem_ack=1:
  - Push {imem_rdata, fetch_pc}; fetch_pc += 4 (32-bit wrap, so FFFF_FFFC -> 0000_0000).
  - Back-to-back: if the issue rule still holds (counting the push and any same-cycle pop), stay in REQ with imem_addr = new fetch_pc and imem_req held high.
  - Otherwise go to IDLE with imem_req=0.
- REQ, no ack: hold the current request.
- Redirect in IDLE:
  - count=0 and fetch_pc=redirect_pc & ~3; stay IDLE.
  - The issue rule is evaluated from the next cycle.
- Redirect in REQ:
  - Without a same-cycle ack: flush, load fetch_pc, go to DISCARD. The old request is held (same address, imem_req=1) until ack, and that data is dropped.
  - With a same-cycle ack: drop the data, flush, go to IDLE.
- DISCARD:
  - On ack, drop the data and go to IDLE.
  - A further redirect only reloads fetch_pc.
- Pop:
  - Occurs when inst_valid & inst_ready & ~redirect.
  - Push and pop in the same cycle leave count unchanged.
  - Pop on empty is impossible, since inst_valid=0.
  - Push on full is impossible by the reservation rule.
- Output latency: an acked word is visible at the head no earlier than the cycle after ack.
- inst_valid = (count != 0). Outputs come from the head entry combinationally.
- A redirect takes priority over push and pop in the same cycle.

Optional Feature:
- IFQ_BYPASS_EN defined:
  - When count=0, state=REQ, imem_ack=1 and no redirect, the head outputs show imem_rdata and imem_addr in the same cycle, with inst_valid=1.
  - If inst_ready=1 that cycle, the word is consumed and not pushed.
  - Otherwise the word is pushed as normal.
- IFQ_BYPASS_EN undefined: minimum ack-to-inst_valid latency is 1 cycle.

Test Plan:
- Reset, then memory acks every request after 1 cycle with inst_ready=1: imem_addr sequence 3000, 3004, 3008; inst_pc follows the same sequence and inst_npc=3004 for the first word.
- inst_ready=0 and a zero-wait memory: count saturates at 4; imem_req stays low afterwards; raising inst_ready for one cycle gives count 3 -> one new request at 3010.
- Redirect to 0000_4001 while the 3008 request waits 3 cycles:
  - imem_addr stays 3008 until ack and that data is dropped;
  - the next request is 4000;
  - inst_valid=0 until the 4000 word arrives.
- Redirect in the same cycle as the ack for 3004: the word is not pushed, count=0, and the next imem_addr is the redirect target.
- Wrap: redirect to FFFF_FFFC, two acks: inst_pc FFFF_FFFC then 0000_0000; inst_npc of the first entry = 0000_0000.
- Reset pulled low while in REQ with count=2: the next cycle shows count=0, imem_req=0, inst_valid=0; after release the first request is 3000.
